// File: rtl/spm_boot_loader_if.sv
// Byte-stream input and SPM port of the boot loader, bundled for the loader (master)
// and for whatever sits on the other side: stream source plus SPM (slave).
interface spm_boot_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] spm_addr;
    logic              spm_as_;
    logic              spm_rw;
    logic [31:0]       spm_wr_data;
    logic [31:0]       spm_rd_data;

    modport master (
        input  rx_data, rx_valid, spm_rd_data,
        output rx_ready, spm_addr, spm_as_, spm_rw, spm_wr_data
    );

    modport slave (
        output rx_data, rx_valid, spm_rd_data,
        input  rx_ready, spm_addr, spm_as_, spm_rw, spm_wr_data
    );
endinterface

// File: rtl/spm_boot_loader.sv
// Boot-time SPM loader: packs a byte stream into little-endian words, writes them to
// consecutive SPM addresses, then reads everything back and compares the sums.
module spm_boot_loader #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    spm_boot_loader_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              chk_err,
    output logic [31:0]       checksum
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RECV    = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        state_reg, state_next;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   idx_reg;
    logic [ADDR_W:0]   idx_inc;
    logic [1:0]        byte_idx_reg;
    logic [31:0]       word_reg;
    logic [31:0]       checksum_reg;
    logic [31:0]       rdsum_reg;
    logic [31:0]       rdsum_next;
    logic              chk_err_reg;
    logic              last_word;
    logic              rx_xfer;
    logic              wr_cyc;
    logic              rd_cyc;

    assign idx_inc    = idx_reg + 1'b1;
    assign last_word  = (idx_inc == count_reg);
    assign rdsum_next = rdsum_reg + bus.spm_rd_data;
    assign rx_xfer    = bus.rx_valid && (state_reg == S_RECV);

    assign busy = (state_reg == S_RECV) || (state_reg == S_WRITE) ||
                  (state_reg == S_RD_ADDR) || (state_reg == S_RD_DATA);

    // An abort cycle must not strobe the SPM, even in WRITE or RD_ADDR.
    assign wr_cyc = (state_reg == S_WRITE) && !abort;
    assign rd_cyc = (state_reg == S_RD_ADDR) && !abort;

    assign bus.rx_ready    = (state_reg == S_RECV);
    assign bus.spm_as_     = !(wr_cyc || rd_cyc);
    assign bus.spm_rw      = !wr_cyc;
    assign bus.spm_addr    = ((state_reg == S_WRITE) || (state_reg == S_RD_ADDR)) ?
                             BASE_ADDR + idx_reg[ADDR_W-1:0] : '0;
    assign bus.spm_wr_data = word_reg;

    assign done     = (state_reg == S_DONE);
    assign chk_err  = chk_err_reg;
    assign checksum = checksum_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = (word_count == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (rx_xfer && (byte_idx_reg == 2'd3)) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE:   state_next = last_word ? S_RD_ADDR : S_RECV;
            S_RD_ADDR: state_next = S_RD_DATA;
            S_RD_DATA: state_next = last_word ? S_DONE : S_RD_ADDR;
            default:   state_next = S_IDLE;
        endcase
        if (busy && abort) begin
            state_next = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            idx_reg      <= '0;
            byte_idx_reg <= '0;
            word_reg     <= '0;
            checksum_reg <= '0;
            rdsum_reg    <= '0;
            chk_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (!busy) begin
                if (start) begin
                    count_reg    <= word_count;
                    idx_reg      <= '0;
                    byte_idx_reg <= '0;
                    checksum_reg <= '0;
                    rdsum_reg    <= '0;
                    chk_err_reg  <= 1'b0;
                end
            end else if (abort) begin
                chk_err_reg <= 1'b1;
            end else begin
                case (state_reg)
                    S_RECV: begin
                        if (rx_xfer) begin
                            word_reg[{byte_idx_reg, 3'b000} +: 8] <= bus.rx_data;
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                        end
                    end
                    S_WRITE: begin
                        checksum_reg <= checksum_reg + word_reg;
                        idx_reg      <= last_word ? '0 : idx_inc;
                    end
                    S_RD_DATA: begin
                        rdsum_reg <= rdsum_next;
                        idx_reg   <= idx_inc;
                        if (last_word) begin
                            chk_err_reg <= (rdsum_next != checksum_reg);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spm_boot_loader.sv
// Drives two loaders (base 0x000 and base 0xFFF) with identical random byte streams and
// checks their SPM traffic and results against a word-level model of the load.
module tb_spm_boot_loader;
    localparam int AW   = 12;
    localparam int NLOG = 8192;

    logic          clk = 1'b0;
    logic          reset_;
    logic          start;
    logic [AW:0]   word_count;
    logic          abort;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [1:0]    busy_v, done_v, chkerr_v;
    logic [31:0]   checksum_v [2];

    always #5 clk = ~clk;

    spm_boot_loader_if #(.ADDR_W(AW)) bus0 ();
    spm_boot_loader_if #(.ADDR_W(AW)) bus1 ();

    assign bus0.rx_data  = rx_data;
    assign bus0.rx_valid = rx_valid;
    assign bus1.rx_data  = rx_data;
    assign bus1.rx_valid = rx_valid;

    spm_boot_loader #(.ADDR_W(AW), .BASE_ADDR(12'h000)) dut0 (
        .clk(clk), .reset_(reset_), .start(start), .word_count(word_count), .abort(abort),
        .bus(bus0), .busy(busy_v[0]), .done(done_v[0]), .chk_err(chkerr_v[0]),
        .checksum(checksum_v[0])
    );

    spm_boot_loader #(.ADDR_W(AW), .BASE_ADDR(12'hFFF)) dut1 (
        .clk(clk), .reset_(reset_), .start(start), .word_count(word_count), .abort(abort),
        .bus(bus1), .busy(busy_v[1]), .done(done_v[1]), .chk_err(chkerr_v[1]),
        .checksum(checksum_v[1])
    );

    // SPM models and bus loggers for both loaders
    int            base_of [2] = '{0, 4095};
    logic [1:0]    as_v, rw_v;
    logic [AW-1:0] addr_v [2];
    logic [31:0]   wd_v [2];
    logic [31:0]   rdq [2];
    logic [31:0]   mem [2][4096];
    logic [AW-1:0] wlog_a [2][NLOG];
    logic [31:0]   wlog_d [2][NLOG];
    logic [AW-1:0] rlog_a [2][NLOG];
    int            wr_n [2]         = '{0, 0};
    int            rd_n [2]         = '{0, 0};
    int            overlap_n [2]    = '{0, 0};
    int            rst_strobe_n [2] = '{0, 0};
    logic [1:0]    prev_wr = 2'b00, prev_rd = 2'b00;
    bit            corrupt_en;
    logic [AW-1:0] corrupt_a [2];

    assign as_v      = {bus1.spm_as_, bus0.spm_as_};
    assign rw_v      = {bus1.spm_rw, bus0.spm_rw};
    assign addr_v[0] = bus0.spm_addr;
    assign addr_v[1] = bus1.spm_addr;
    assign wd_v[0]   = bus0.spm_wr_data;
    assign wd_v[1]   = bus1.spm_wr_data;
    assign bus0.spm_rd_data = rdq[0];
    assign bus1.spm_rd_data = rdq[1];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!as_v[d] && !rw_v[d]) begin
                mem[d][addr_v[d]] <= wd_v[d];
                if (wr_n[d] < NLOG) begin
                    wlog_a[d][wr_n[d]] <= addr_v[d];
                    wlog_d[d][wr_n[d]] <= wd_v[d];
                end
                wr_n[d] <= wr_n[d] + 1;
                if (prev_wr[d]) overlap_n[d] <= overlap_n[d] + 1;
            end
            if (!as_v[d] && rw_v[d]) begin
                if (rd_n[d] < NLOG) rlog_a[d][rd_n[d]] <= addr_v[d];
                rd_n[d] <= rd_n[d] + 1;
                rdq[d]  <= mem[d][addr_v[d]] ^ {31'b0, corrupt_en && (addr_v[d] == corrupt_a[d])};
                if (prev_rd[d]) overlap_n[d] <= overlap_n[d] + 1;
            end
            if (!as_v[d] && !reset_) rst_strobe_n[d] <= rst_strobe_n[d] + 1;
            prev_wr[d] <= !as_v[d] && !rw_v[d];
            prev_rd[d] <= !as_v[d] && rw_v[d];
        end
    end

    int         checks = 0;
    int         errors = 0;
    int         hs_to;
    logic [7:0] bq [16384];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit toggle);
        bit sent = 1'b0;
        int g = 0;
        while (!sent && g < 100) begin
            @(negedge clk);
            g++;
            if (toggle && rx_valid) begin
                rx_valid = 1'b0;
            end else begin
                rx_data  = b;
                rx_valid = 1'b1;
                sent     = bus0.rx_ready;
            end
        end
        if (!sent) hs_to++;
    endtask

    task automatic fill_random(input int nbytes);
        for (int i = 0; i < nbytes; i++) bq[i] = 8'($urandom);
    endtask

    // One load, then every result compared with the word-level expectation.
    task automatic run_load(input int n, input int abort_after, input bit toggle,
                            input bit corrupt, input bit busy_start);
        int w0 [2], r0 [2], o0 [2];
        int nw, nsend, mis, g;
        logic [31:0] ew [$];
        logic [31:0] cs, w;
        bit ee;
        for (int d = 0; d < 2; d++) begin
            w0[d] = wr_n[d]; r0[d] = rd_n[d]; o0[d] = overlap_n[d];
            corrupt_a[d] = AW'((base_of[d] + 1) % 4096);
        end
        corrupt_en = corrupt;
        hs_to = 0;
        @(negedge clk);
        word_count = (AW+1)'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nsend = (abort_after >= 0) ? abort_after : 4 * n;
        for (int i = 0; i < nsend; i++) begin
            send_byte(bq[i], toggle);
            if (busy_start && i == 1) begin
                @(negedge clk);
                rx_valid = 1'b0;
                start = 1'b1;
                word_count = 13'd1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        if (abort_after >= 0) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        g = 0;
        while (done_v != 2'b11 && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("done_wait", 32'(done_v), 32'h3);
        chk("rx_handshake_timeouts", 32'(hs_to), 32'h0);

        nw = (abort_after >= 0) ? abort_after / 4 : n;
        cs = 32'h0;
        for (int i = 0; i < nw; i++) begin
            w = 32'(bq[4*i]) | (32'(bq[4*i+1]) << 8) | (32'(bq[4*i+2]) << 16) | (32'(bq[4*i+3]) << 24);
            ew.push_back(w);
            cs += w;
        end
        ee = (abort_after >= 0) ? 1'b1 : (corrupt && n > 1);

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("done%0d", d), 32'(done_v[d]), 32'h1);
            chk($sformatf("chk_err%0d", d), 32'(chkerr_v[d]), 32'(ee));
            chk($sformatf("checksum%0d", d), checksum_v[d], cs);
            chk($sformatf("busy%0d", d), 32'(busy_v[d]), 32'h0);
            chk($sformatf("writes%0d", d), 32'(wr_n[d] - w0[d]), 32'(nw));
            chk($sformatf("reads%0d", d), 32'(rd_n[d] - r0[d]), (abort_after >= 0) ? 32'h0 : 32'(n));
            mis = 0;
            for (int i = 0; i < nw; i++) begin
                if (wlog_a[d][w0[d]+i] !== AW'((base_of[d] + i) % 4096) || wlog_d[d][w0[d]+i] !== ew[i])
                    mis++;
            end
            chk($sformatf("write_log_mismatches%0d", d), 32'(mis), 32'h0);
            mis = 0;
            if (abort_after < 0) begin
                for (int i = 0; i < n; i++) begin
                    if (rlog_a[d][r0[d]+i] !== AW'((base_of[d] + i) % 4096)) mis++;
                end
            end
            chk($sformatf("read_log_mismatches%0d", d), 32'(mis), 32'h0);
            chk($sformatf("strobe_overlaps%0d", d), 32'(overlap_n[d] - o0[d]), 32'h0);
        end
        $display("load n=%0d abort_after=%0d toggle=%0d corrupt=%0d busy_start=%0d checksum=%08h chk_err=%0b",
                 n, abort_after, toggle, corrupt, busy_start, checksum_v[0], chkerr_v[0]);
    endtask

    initial begin
        int w0 [2];
        reset_ = 1'b0; start = 1'b0; abort = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; word_count = '0;
        corrupt_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_as0", 32'(bus0.spm_as_), 32'h1);
        chk("rst_rw0", 32'(bus0.spm_rw), 32'h1);
        chk("rst_rx_ready0", 32'(bus0.rx_ready), 32'h0);
        chk("rst_addr1", 32'(bus1.spm_addr), 32'h0);
        chk("rst_wr_data0", bus0.spm_wr_data, 32'h0);
        chk("rst_busy", 32'(busy_v), 32'h0);
        chk("rst_done", 32'(done_v), 32'h0);
        chk("rst_chk_err", 32'(chkerr_v), 32'h0);
        chk("rst_checksum0", checksum_v[0], 32'h0);
        reset_ = 1'b1;

        for (int i = 0; i < 8; i++) bq[i] = 8'(i + 1);
        run_load(2, -1, 1'b0, 1'b0, 1'b0);
        run_load(2, -1, 1'b0, 1'b1, 1'b0);

        fill_random(20);
        run_load(5, -1, 1'b1, 1'b0, 1'b0);
        fill_random(12);
        run_load(3, -1, 1'b0, 1'b0, 1'b1);

        for (int d = 0; d < 2; d++) w0[d] = wr_n[d] + rd_n[d];
        @(negedge clk);
        word_count = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", 32'(done_v), 32'h3);
        chk("zero_busy", 32'(busy_v), 32'h0);
        chk("zero_chk_err", 32'(chkerr_v), 32'h0);
        chk("zero_checksum0", checksum_v[0], 32'h0);
        repeat (3) @(negedge clk);
        chk("zero_strobes0", 32'(wr_n[0] + rd_n[0] - w0[0]), 32'h0);
        chk("zero_strobes1", 32'(wr_n[1] + rd_n[1] - w0[1]), 32'h0);

        fill_random(12);
        run_load(3, 6, 1'b0, 1'b0, 1'b0);
        fill_random(12);
        run_load(3, -1, 1'b0, 1'b0, 1'b0);

        fill_random(8);
        @(negedge clk);
        word_count = 13'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(bq[0], 1'b0);
        send_byte(bq[1], 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("busy_before_reset", 32'(busy_v), 32'h3);
        @(posedge clk);
        #2 reset_ = 1'b0;
        #1;
        chk("async_rst_as0", 32'(bus0.spm_as_), 32'h1);
        chk("async_rst_as1", 32'(bus1.spm_as_), 32'h1);
        chk("async_rst_rx_ready", 32'(bus0.rx_ready), 32'h0);
        chk("async_rst_busy", 32'(busy_v), 32'h0);
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        chk("post_rst_done", 32'(done_v), 32'h0);
        chk("post_rst_checksum1", checksum_v[1], 32'h0);
        chk("rst_strobes0", 32'(rst_strobe_n[0]), 32'h0);
        chk("rst_strobes1", 32'(rst_strobe_n[1]), 32'h0);

        for (int k = 0; k < 3; k++) begin
            int n;
            n = int'($urandom_range(1, 6));
            fill_random(4 * n);
            run_load(n, -1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        fill_random(16384);
        run_load(4096, -1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
